// File: rtl/fft_fp_pkg.sv
// fft_fp_pkg: shared IEEE-754 single-precision types and constants for the FFT float consumers.
package fft_fp_pkg;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_MAX  = 255;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;
endpackage

// File: rtl/fl_unpack.sv
// fl_unpack: combinational float classify, hidden-bit insertion and fixed-point shift computation.
// Ports: data (float in), cls (zero/norm/inf/nan), sign (forced 0 for zero/denormal),
//        sig (24-bit significand with hidden bit), shift (signed left-shift amount exp-150+FRAC).
module fl_unpack
    import fft_fp_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic              [31:0] data,
    output fp_class_t                cls,
    output logic                     sign,
    output logic              [23:0] sig,
    output logic signed       [9:0]  shift
);
    fp32_t f;
    logic  nz;
    assign f  = data;
    assign nz = f.exp != '0;
    always_comb begin
        cls   = !nz ? FP_ZERO : f.exp == 8'(FP_EXP_MAX) ? (f.mant == '0 ? FP_INF : FP_NAN) : FP_NORM;
        sign  = f.sign & nz;
        sig   = {nz, f.mant};
        shift = 10'({2'b00, f.exp}) - 10'(FP_EXP_BIAS + FP_MANT_W) + 10'(FRAC);
    end
endmodule

// File: rtl/fl2fix_converter.sv
// fl2fix_converter: 3-stage pipelined IEEE-754 single to signed WIDTH-bit fixed point (FRAC fraction bits).
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready input handshake;
//        out_data/out_ovf/out_valid/out_ready output handshake. out_ovf flags saturation or Inf/NaN.
// Build option: define FL2FIX_ROUND_EN for round-half-away-from-zero; otherwise truncate toward zero.
module fl2fix_converter
    import fft_fp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic signed [9:0] SH_MAX  = 10'(WIDTH - 1);
    localparam logic [WIDTH:0]    POS_LIM = (WIDTH+1)'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [WIDTH:0]    NEG_LIM = (WIDTH+1)'(64'd1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0]  MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};

    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    fp_class_t          cls_u;
    logic               sign_u;
    logic [23:0]        sig_u;
    logic signed [9:0]  shift_u;

    fl_unpack #(.FRAC(FRAC)) u_unpack (
        .data  (in_data),
        .cls   (cls_u),
        .sign  (sign_u),
        .sig   (sig_u),
        .shift (shift_u)
    );

    logic               v1, sg1;
    fp_class_t          c1;
    logic [23:0]        sig1;
    logic signed [9:0]  sh1;

    logic               v2, sg2, ovf2;
    fp_class_t          c2;
    logic [WIDTH-1:0]   mag2;

    // Stage 2: align the significand into a wide window, flag anything above WIDTH bits.
    // Bit WIDTH-1 is kept so that -2^(WIDTH-1) survives; stage 3 decides by sign.
    logic signed [9:0]  nsh;
    logic [5:0]         rsh;
    logic [63:0]        wide;
    logic               ovf_a;
`ifdef FL2FIX_ROUND_EN
    logic               g2, guard_a;
    logic [24:0]        ext;
    always_comb begin
        nsh     = -sh1;
        rsh     = nsh > 10'sd31 ? 6'd31 : nsh[5:0];
        ext     = {sig1, 1'b0} >> rsh;
        guard_a = sh1 < 0 && ext[0];
        wide    = sh1 < 0 ? 64'(ext[24:1]) : 64'(sig1) << sh1[5:0];
        ovf_a   = (sh1 >= SH_MAX) || |wide[63:WIDTH];
    end
`else
    logic [23:0]        ext;
    always_comb begin
        nsh   = -sh1;
        rsh   = nsh > 10'sd31 ? 6'd31 : nsh[5:0];
        ext   = sig1 >> rsh;
        wide  = sh1 < 0 ? 64'(ext) : 64'(sig1) << sh1[5:0];
        ovf_a = (sh1 >= SH_MAX) || |wide[63:WIDTH];
    end
`endif

    // Stage 3: round, saturate by sign (negative side allows exactly 2^(WIDTH-1)), negate.
    logic [WIDTH:0]     mr;
    logic               sat;
    logic [WIDTH-1:0]   d3;
    logic               o3;
    always_comb begin
`ifdef FL2FIX_ROUND_EN
        mr  = {1'b0, mag2} + (WIDTH+1)'(g2);
`else
        mr  = {1'b0, mag2};
`endif
        sat = ovf2 || mr > (sg2 ? NEG_LIM : POS_LIM);
        d3  = (c2 == FP_NAN || c2 == FP_ZERO) ? '0 :
              (c2 == FP_INF || sat) ? (sg2 ? MIN_V : MAX_V) :
              sg2 ? -mr[WIDTH-1:0] : mr[WIDTH-1:0];
        o3  = c2 == FP_NAN || c2 == FP_INF || (c2 == FP_NORM && sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            c1        <= cls_u;
            sg1       <= sign_u;
            sig1      <= sig_u;
            sh1       <= shift_u;
            v2        <= v1;
            c2        <= c1;
            sg2       <= sg1;
            mag2      <= wide[WIDTH-1:0];
            ovf2      <= ovf_a;
`ifdef FL2FIX_ROUND_EN
            g2        <= guard_a;
`endif
            out_valid <= v2;
            out_data  <= d3;
            out_ovf   <= o3;
        end
    end
endmodule

// File: tb/tb_fl2fix_converter.sv
// tb_fl2fix_converter: scoreboard bench for fl2fix_converter (WIDTH=16, FRAC=8) with directed vectors.
module tb_fl2fix_converter;
`ifdef FL2FIX_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready, out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_ovf, out_valid;

    fl2fix_converter #(.WIDTH(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] d; logic o; int acc; bit lat;} exp_t;
    typedef struct {logic [31:0] v; logic [15:0] d; logic o;} vec_t;
    exp_t q[$];
    exp_t e;
    vec_t vecs[$];
    int total = 0, bad = 0, cyc = 0, pushed = 0, popped = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid | out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got %h want none", out_data);
                end else begin
                    e = q.pop_front();
                    popped++;
                    chk("data", 32'(out_data), 32'(e.d));
                    chk("ovf", 32'(out_ovf), 32'(e.o));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [15:0] d, input logic o, input bit lat, input bit push);
        int n;
        @(posedge clk) #1;
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end
        if (push) begin
            q.push_back('{d, o, cyc, lat});
            pushed++;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk) #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    endtask

    initial begin
        vecs.push_back('{32'h3F800000, 16'h0100, 1'b0});
        vecs.push_back('{32'hC0200000, 16'hFD80, 1'b0});
        vecs.push_back('{32'h43480000, 16'h7FFF, 1'b1});
        vecs.push_back('{32'hC3000000, 16'h8000, 1'b0});
        vecs.push_back('{32'h7F800000, 16'h7FFF, 1'b1});
        vecs.push_back('{32'hFF800000, 16'h8000, 1'b1});
        vecs.push_back('{32'h7FC00000, 16'h0000, 1'b1});
        vecs.push_back('{32'h3B800000, 16'h0001, 1'b0});
        vecs.push_back('{32'h3B000000, RND ? 16'h0001 : 16'h0000, 1'b0});
        vecs.push_back('{32'hBB000000, RND ? 16'hFFFF : 16'h0000, 1'b0});
        vecs.push_back('{32'h3BC00000, RND ? 16'h0002 : 16'h0001, 1'b0});
        vecs.push_back('{32'h00000001, 16'h0000, 1'b0});
        vecs.push_back('{32'h80000001, 16'h0000, 1'b0});
        vecs.push_back('{32'h00000000, 16'h0000, 1'b0});
        vecs.push_back('{32'h7F000000, 16'h7FFF, 1'b1});
        vecs.push_back('{32'hC3480000, 16'h8000, 1'b1});
        vecs.push_back('{32'h42FFFF00, 16'h7FFF, RND});
        vecs.push_back('{32'hC2FFFF00, RND ? 16'h8000 : 16'h8001, 1'b0});
        vecs.push_back('{32'hBF800000, 16'hFF00, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        send(vecs[0].v, vecs[0].d, vecs[0].o, 1'b1, 1'b1);
        idle(6);
        send(vecs[1].v, vecs[1].d, vecs[1].o, 1'b1, 1'b1);
        idle(6);
        foreach (vecs[i]) send(vecs[i].v, vecs[i].d, vecs[i].o, 1'b1, 1'b1);
        idle(2);
        drain();

        fork
            begin
                for (int i = 0; i < 5; i++) send(vecs[i].v, vecs[i].d, vecs[i].o, 1'b0, 1'b1);
                idle(1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h43000000, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        send(32'h40000000, 16'h0200, 1'b0, 1'b0, 1'b0);
        @(posedge clk) #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        send(32'h3F800000, 16'h0100, 1'b0, 1'b1, 1'b1);
        idle(2);
        drain();

        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("count", 32'(popped), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
